// File: rtl/fpnew_aux_fsm_multi.sv
// fpnew_aux_fsm_multi: handshake and tag/aux carrier for FPNew lanes built
// from iterative FSMs. Operations pass through optional elastic input stages,
// are dispatched round-robin into NumUnits slots, and retire strictly in issue
// order through optional elastic output stages.
module fpnew_aux_fsm_multi #(
  parameter int unsigned  NumUnits   = 2,
  parameter int unsigned  NumInRegs  = 0,
  parameter int unsigned  NumOutRegs = 0,
  parameter type          TagType    = logic,
  parameter type          AuxType    = logic,
  localparam int unsigned RegEnW     = ((NumInRegs + NumOutRegs) > 0) ? (NumInRegs + NumOutRegs) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  TagType              tag_i,
  input  AuxType              aux_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output TagType              tag_o,
  output AuxType              aux_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [RegEnW-1:0]   reg_enable_o,
  output logic [NumUnits-1:0] fsm_start_o,
  input  logic [NumUnits-1:0] fsm_ready_i,
  output logic                busy_o
);

  localparam int unsigned PtrW = (NumUnits > 1) ? $clog2(NumUnits) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} slot_state_e;

  // Input chain: index 0 is the module input, index NumInRegs the dispatch stage.
  // w_iq[i] is the valid held in input register i; the last entry is a constant 0.
  logic   w_ivld [NumInRegs+1];
  logic   w_iq   [NumInRegs+1];
  logic   w_irdy [NumInRegs+1];
  TagType w_itag [NumInRegs+1];
  AuxType w_iaux [NumInRegs+1];

  // Output chain: index 0 is the retire stage, index NumOutRegs the module output.
  logic   w_ovld [NumOutRegs+1];
  logic   w_oq   [NumOutRegs+1];
  logic   w_ordy [NumOutRegs+1];
  TagType w_otag [NumOutRegs+1];
  AuxType w_oaux [NumOutRegs+1];

  logic [RegEnW-1:0]   w_reg_en;
  slot_state_e         r_state     [NumUnits];
  slot_state_e         w_state_nxt [NumUnits];
  TagType              r_slot_tag  [NumUnits];
  AuxType              r_slot_aux  [NumUnits];
  logic [PtrW-1:0]     r_disp_ptr, r_ret_ptr, w_disp_ptr_nxt, w_ret_ptr_nxt;
  logic [NumUnits-1:0] w_start;
  logic                w_disp_ready, w_dispatch, w_slot_free;
  logic                w_ret_valid, w_retire, w_busy;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(NumUnits - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_ivld[0]         = in_valid_i;
  assign w_itag[0]         = tag_i;
  assign w_iaux[0]         = aux_i;
  assign w_iq[NumInRegs]   = 1'b0;

  for (genvar i = 0; i < NumInRegs; i++) begin : g_in
    logic   r_vld;
    TagType r_tag;
    AuxType r_aux;
    // Input stage valid: flushable control register
    always_ff @(posedge clk_i) begin
      if (!rst_ni)        r_vld <= 1'b0;
      else if (flush_i)   r_vld <= 1'b0;
      else if (w_irdy[i]) r_vld <= w_ivld[i];
    end
    // Input stage data: loads only on the lane register enable
    always_ff @(posedge clk_i) begin
      if (w_irdy[i] && w_ivld[i]) begin
        r_tag <= w_itag[i];
        r_aux <= w_iaux[i];
      end
    end
    assign w_iq[i]     = r_vld;
    assign w_ivld[i+1] = r_vld;
    assign w_itag[i+1] = r_tag;
    assign w_iaux[i+1] = r_aux;
    assign w_reg_en[i] = w_irdy[i] & w_ivld[i];
  end

  assign w_ovld[0]          = w_ret_valid;
  assign w_otag[0]          = r_slot_tag[r_ret_ptr];
  assign w_oaux[0]          = r_slot_aux[r_ret_ptr];
  assign w_oq[NumOutRegs]   = 1'b0;

  for (genvar j = 0; j < NumOutRegs; j++) begin : g_out
    logic   r_vld;
    TagType r_tag;
    AuxType r_aux;
    // Output stage valid: flushable control register
    always_ff @(posedge clk_i) begin
      if (!rst_ni)        r_vld <= 1'b0;
      else if (flush_i)   r_vld <= 1'b0;
      else if (w_ordy[j]) r_vld <= w_ovld[j];
    end
    // Output stage data: loads only on the lane register enable
    always_ff @(posedge clk_i) begin
      if (w_ordy[j] && w_ovld[j]) begin
        r_tag <= w_otag[j];
        r_aux <= w_oaux[j];
      end
    end
    assign w_oq[j]                 = r_vld;
    assign w_ovld[j+1]             = r_vld;
    assign w_otag[j+1]             = r_tag;
    assign w_oaux[j+1]             = r_aux;
    assign w_reg_en[NumInRegs + j] = w_ordy[j] & w_ovld[j];
  end

  if ((NumInRegs + NumOutRegs) == 0) begin : g_no_regs
    assign w_reg_en = '0;
  end

  // Elastic ready chains: a stage accepts when downstream accepts or it is empty
  always_comb begin
    w_irdy[NumInRegs] = w_disp_ready;
    for (int i = int'(NumInRegs) - 1; i >= 0; i--) w_irdy[i] = w_irdy[i+1] | ~w_iq[i];
    w_ordy[NumOutRegs] = out_ready_i;
    for (int j = int'(NumOutRegs) - 1; j >= 0; j--) w_ordy[j] = w_ordy[j+1] | ~w_oq[j];
  end

  // Busy whenever any stage holds data or any slot is occupied
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i <= int'(NumInRegs); i++)  w_busy = w_busy | w_iq[i];
    for (int j = 0; j <= int'(NumOutRegs); j++) w_busy = w_busy | w_oq[j];
    for (int k = 0; k < int'(NumUnits); k++)    w_busy = w_busy | (r_state[k] != S_IDLE);
  end

  // Slot next-state: in-order retire, round-robin dispatch with same-cycle reuse, flush last
  always_comb begin
    w_ret_valid    = (r_state[r_ret_ptr] == S_DONE) && !flush_i;
    w_retire       = w_ret_valid && w_ordy[0];
    w_slot_free    = (r_state[r_disp_ptr] == S_IDLE) ||
                     ((r_state[r_disp_ptr] == S_DONE) && w_retire && (r_ret_ptr == r_disp_ptr));
    w_disp_ready   = w_slot_free;
    w_dispatch     = w_ivld[NumInRegs] && w_slot_free && !flush_i;
    w_start        = '0;
    w_disp_ptr_nxt = r_disp_ptr;
    w_ret_ptr_nxt  = r_ret_ptr;
    for (int k = 0; k < int'(NumUnits); k++) begin
      w_state_nxt[k] = r_state[k];
      unique case (r_state[k])
        S_BUSY:  if (fsm_ready_i[k]) w_state_nxt[k] = S_DONE;
        S_DONE:  if (w_retire && (r_ret_ptr == PtrW'(k))) w_state_nxt[k] = S_IDLE;
        default: ;
      endcase
    end
    if (w_retire) w_ret_ptr_nxt = ptr_inc(r_ret_ptr);
    if (w_dispatch) begin
      w_start[r_disp_ptr]     = 1'b1;
      // The lane may finish within the start cycle itself
      w_state_nxt[r_disp_ptr] = fsm_ready_i[r_disp_ptr] ? S_DONE : S_BUSY;
      w_disp_ptr_nxt          = ptr_inc(r_disp_ptr);
    end
    if (flush_i) begin
      for (int k = 0; k < int'(NumUnits); k++) w_state_nxt[k] = S_IDLE;
      w_disp_ptr_nxt = '0;
      w_ret_ptr_nxt  = '0;
    end
  end

  // Slot state, pointers and held tag/aux
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_disp_ptr <= '0;
      r_ret_ptr  <= '0;
      for (int k = 0; k < int'(NumUnits); k++) begin
        r_state[k]    <= S_IDLE;
        r_slot_tag[k] <= '0;
        r_slot_aux[k] <= '0;
      end
    end else begin
      r_disp_ptr <= w_disp_ptr_nxt;
      r_ret_ptr  <= w_ret_ptr_nxt;
      for (int k = 0; k < int'(NumUnits); k++) begin
        r_state[k] <= w_state_nxt[k];
        if (w_start[k]) begin
          r_slot_tag[k] <= w_itag[NumInRegs];
          r_slot_aux[k] <= w_iaux[NumInRegs];
        end
      end
    end
  end

  assign in_ready_o   = w_irdy[0];
  assign out_valid_o  = w_ovld[NumOutRegs];
  assign tag_o        = w_otag[NumOutRegs];
  assign aux_o        = w_oaux[NumOutRegs];
  assign reg_enable_o = w_reg_en;
  assign fsm_start_o  = w_start;
  assign busy_o       = w_busy;

endmodule

// File: tb/tb_fpnew_aux_fsm_multi.sv
// Bench for fpnew_aux_fsm_multi: directed scenarios on two configurations
// (no pipeline regs, and one input reg) plus a randomized in-order scoreboard.
module tb_fpnew_aux_fsm_multi;
  typedef logic [3:0] tag_t;
  typedef logic [7:0] aux_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  tag_t a_tag, a_tag_o;
  aux_t a_aux, a_aux_o;
  logic a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_busy;
  logic [0:0] a_reg_en;
  logic [1:0] a_start, a_fsm_ready;

  tag_t b_tag, b_tag_o;
  aux_t b_aux, b_aux_o;
  logic b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_busy;
  logic [0:0] b_reg_en;
  logic [1:0] b_start, b_fsm_ready;

  int total = 0;
  int bad = 0;
  tag_t got_tag[$];
  aux_t got_aux[$];

  fpnew_aux_fsm_multi #(.NumUnits(2), .NumInRegs(0), .NumOutRegs(0), .TagType(tag_t), .AuxType(aux_t)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tag_i(a_tag), .aux_i(a_aux), .in_valid_i(a_in_valid),
    .in_ready_o(a_in_ready), .flush_i(a_flush), .tag_o(a_tag_o), .aux_o(a_aux_o),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .reg_enable_o(a_reg_en),
    .fsm_start_o(a_start), .fsm_ready_i(a_fsm_ready), .busy_o(a_busy));

  fpnew_aux_fsm_multi #(.NumUnits(2), .NumInRegs(1), .NumOutRegs(0), .TagType(tag_t), .AuxType(aux_t)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tag_i(b_tag), .aux_i(b_aux), .in_valid_i(b_in_valid),
    .in_ready_o(b_in_ready), .flush_i(b_flush), .tag_o(b_tag_o), .aux_o(b_aux_o),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .reg_enable_o(b_reg_en),
    .fsm_start_o(b_start), .fsm_ready_i(b_fsm_ready), .busy_o(b_busy));

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in_valid = 0; a_tag = '0; a_aux = '0; a_flush = 0; a_out_ready = 1; a_fsm_ready = '0;
    b_in_valid = 0; b_tag = '0; b_aux = '0; b_flush = 0; b_out_ready = 1; b_fsm_ready = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  // Records every output handshake of DUT A for n cycles with the current inputs
  task automatic collect_a(input int n);
    for (int c = 0; c < n; c++) begin
      #1;
      if (a_out_valid && a_out_ready) begin
        got_tag.push_back(a_tag_o);
        got_aux.push_back(a_aux_o);
      end
      step();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); end
    total++; if (a_start !== 2'b00) begin bad++; $display("FAIL rst_start got=%b exp=00", a_start); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", a_in_ready); end
    total++; if (a_reg_en !== 1'b0) begin bad++; $display("FAIL rst_reg_en got=%b exp=0", a_reg_en); end
    total++; if (b_busy !== 1'b0 || b_in_ready !== 1'b1) begin bad++; $display("FAIL rst_b busy/ready got=%b%b exp=01", b_busy, b_in_ready); end
    step();
  endtask

  task automatic test_order();
    int first = -1;
    do_reset();
    got_tag.delete(); got_aux.delete();
    for (int c = 0; c < 12; c++) begin
      a_in_valid  = (c < 2);
      a_tag       = (c == 0) ? tag_t'(1) : tag_t'(2);
      a_aux       = (c == 0) ? 8'h11 : 8'h22;
      a_fsm_ready = {(c >= 2), (c >= 5)};
      #1;
      if (c == 0) begin total++; if (a_start !== 2'b01) begin bad++; $display("FAIL order_startA got=%b exp=01", a_start); end end
      if (c == 1) begin total++; if (a_start !== 2'b10) begin bad++; $display("FAIL order_startB got=%b exp=10", a_start); end end
      if (c >= 2 && c <= 5) begin
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL order_hold c=%0d got=%b exp=0", c, a_out_valid); end
      end
      if (a_out_valid === 1'b1) begin
        got_tag.push_back(a_tag_o); got_aux.push_back(a_aux_o);
        if (first < 0) first = c;
      end
      step();
    end
    total++; if (first != 6) begin bad++; $display("FAIL order_first_cycle got=%0d exp=6", first); end
    total++; if (got_tag.size() != 2) begin bad++; $display("FAIL order_count got=%0d exp=2", got_tag.size()); end
    total++; if (got_tag[0] !== 4'd1 || got_aux[0] !== 8'h11) begin bad++; $display("FAIL order_first got=%h/%h exp=1/11", got_tag[0], got_aux[0]); end
    total++; if (got_tag[1] !== 4'd2 || got_aux[1] !== 8'h22) begin bad++; $display("FAIL order_second got=%h/%h exp=2/22", got_tag[1], got_aux[1]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    got_tag.delete(); got_aux.delete();
    a_in_valid = 1; a_tag = 4'd3; a_aux = 8'h33; #1;
    total++; if (a_in_ready !== 1'b1 || a_start !== 2'b01) begin bad++; $display("FAIL b2b_op1 got=%b/%b exp=1/01", a_in_ready, a_start); end
    step();
    a_tag = 4'd4; a_aux = 8'h44; #1;
    total++; if (a_start !== 2'b10) begin bad++; $display("FAIL b2b_op2 got=%b exp=10", a_start); end
    step();
    a_tag = 4'd5; a_aux = 8'h55; #1;
    total++; if (a_in_ready !== 1'b0 || a_start !== 2'b00) begin bad++; $display("FAIL b2b_stall got=%b/%b exp=0/00", a_in_ready, a_start); end
    step();
    a_fsm_ready = 2'b01; #1;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall2 got=%b exp=0", a_in_ready); end
    step();
    a_fsm_ready = 2'b00; #1;
    total++; if (a_out_valid !== 1'b1 || a_tag_o !== 4'd3) begin bad++; $display("FAIL b2b_ret got=%b/%h exp=1/3", a_out_valid, a_tag_o); end
    total++; if (a_in_ready !== 1'b1 || a_start !== 2'b01) begin bad++; $display("FAIL b2b_wrap got=%b/%b exp=1/01", a_in_ready, a_start); end
    step();
    a_in_valid = 0; a_fsm_ready = 2'b11;
    collect_a(6);
    total++; if (got_tag.size() != 2 || got_tag[0] !== 4'd4 || got_tag[1] !== 4'd5)
      begin bad++; $display("FAIL b2b_drain got=%0d:%h,%h exp=2:4,5", got_tag.size(), got_tag[0], got_tag[1]); end
  endtask

  task automatic test_latency();
    do_reset();
    a_fsm_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = (i < 4); a_tag = tag_t'(8 + i); a_aux = aux_t'(8'h80 + i);
      #1;
      if (i < 4) begin
        total++; if (a_in_ready !== 1'b1 || a_start !== ((i % 2 == 0) ? 2'b01 : 2'b10))
          begin bad++; $display("FAIL lat_start i=%0d got=%b/%b", i, a_in_ready, a_start); end
      end
      if (i == 0 || i == 5) begin
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL lat_idle i=%0d got=%b exp=0", i, a_out_valid); end
      end else begin
        total++; if (a_out_valid !== 1'b1 || a_tag_o !== tag_t'(8 + i - 1) || a_aux_o !== aux_t'(8'h80 + i - 1))
          begin bad++; $display("FAIL lat_out i=%0d got=%b/%h/%h exp=1/%h", i, a_out_valid, a_tag_o, a_aux_o, 8 + i - 1); end
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    got_tag.delete(); got_aux.delete();
    a_fsm_ready = 2'b11; a_out_ready = 0;
    a_in_valid = 1; a_tag = 4'd7; a_aux = 8'h77; #1;
    total++; if (a_start !== 2'b01) begin bad++; $display("FAIL stall_start got=%b exp=01", a_start); end
    step();
    a_tag = 4'd8; a_aux = 8'h88;
    for (int c = 1; c <= 4; c++) begin
      #1;
      total++; if (a_out_valid !== 1'b1 || a_tag_o !== 4'd7 || a_aux_o !== 8'h77)
        begin bad++; $display("FAIL stall_hold c=%0d got=%b/%h/%h exp=1/7/77", c, a_out_valid, a_tag_o, a_aux_o); end
      total++; if (a_start[0] !== 1'b0) begin bad++; $display("FAIL stall_nostart c=%0d got=%b exp=0", c, a_start[0]); end
      if (c >= 2) begin total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, a_in_ready); end end
      step();
      a_tag = 4'd11; a_aux = 8'hbb;
    end
    a_out_ready = 1; #1;
    total++; if (a_out_valid !== 1'b1 || a_tag_o !== 4'd7 || a_start !== 2'b01 || a_in_ready !== 1'b1)
      begin bad++; $display("FAIL stall_release got=%b/%h/%b/%b exp=1/7/01/1", a_out_valid, a_tag_o, a_start, a_in_ready); end
    step();
    a_in_valid = 0;
    collect_a(6);
    total++; if (got_tag.size() != 2 || got_tag[0] !== 4'd8 || got_tag[1] !== 4'd11 || got_aux[1] !== 8'hbb)
      begin bad++; $display("FAIL stall_drain got=%0d:%h,%h exp=2:8,b", got_tag.size(), got_tag[0], got_tag[1]); end
  endtask

  task automatic test_flush_priority();
    do_reset();
    a_fsm_ready = 2'b11;
    a_in_valid = 1; a_tag = 4'd1; a_aux = 8'h01;
    step();
    a_tag = 4'd2; a_flush = 1; #1;
    total++; if (a_start !== 2'b00 || a_out_valid !== 1'b0) begin bad++; $display("FAIL fprio_cycle got=%b/%b exp=00/0", a_start, a_out_valid); end
    step();
    a_flush = 0; a_in_valid = 0; #1;
    total++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL fprio_after got=%b/%b exp=0/0", a_out_valid, a_busy); end
    step();
  endtask

  task automatic test_flush();
    do_reset();
    b_fsm_ready = 2'b00;
    b_in_valid = 1; b_tag = 4'd1; b_aux = 8'h01; #1;
    total++; if (b_in_ready !== 1'b1 || b_start !== 2'b00 || b_reg_en !== 1'b1)
      begin bad++; $display("FAIL flush_in got=%b/%b/%b exp=1/00/1", b_in_ready, b_start, b_reg_en); end
    step();
    b_tag = 4'd2; #1;
    total++; if (b_start !== 2'b01) begin bad++; $display("FAIL flush_s0 got=%b exp=01", b_start); end
    step();
    b_tag = 4'd3; #1;
    total++; if (b_start !== 2'b10) begin bad++; $display("FAIL flush_s1 got=%b exp=10", b_start); end
    step();
    b_in_valid = 0; #1;
    total++; if (b_in_ready !== 1'b0 || b_busy !== 1'b1) begin bad++; $display("FAIL flush_full got=%b/%b exp=0/1", b_in_ready, b_busy); end
    b_flush = 1; #1;
    total++; if (b_start !== 2'b00 || b_out_valid !== 1'b0) begin bad++; $display("FAIL flush_cycle got=%b/%b exp=00/0", b_start, b_out_valid); end
    step();
    b_flush = 0; #1;
    total++; if (b_busy !== 1'b0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1)
      begin bad++; $display("FAIL flush_after got=%b/%b/%b exp=0/0/1", b_busy, b_out_valid, b_in_ready); end
    b_in_valid = 1; b_tag = 4'd4; b_aux = 8'h44; b_fsm_ready = 2'b11;
    step();
    b_in_valid = 0; #1;
    total++; if (b_start !== 2'b01) begin bad++; $display("FAIL flush_restart got=%b exp=01", b_start); end
    step(); #1;
    total++; if (b_out_valid !== 1'b1 || b_tag_o !== 4'd4 || b_aux_o !== 8'h44)
      begin bad++; $display("FAIL flush_out got=%b/%h/%h exp=1/4/44", b_out_valid, b_tag_o, b_aux_o); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_in_valid = 1; a_tag = 4'd12; a_aux = 8'hc0;
    step();
    a_tag = 4'd13;
    step();
    a_in_valid = 0; rst_n = 0;
    step();
    rst_n = 1; #1;
    total++; if (a_out_valid !== 1'b0 || a_start !== 2'b00 || a_busy !== 1'b0 || a_in_ready !== 1'b1)
      begin bad++; $display("FAIL rmid_state got=%b/%b/%b/%b exp=0/00/0/1", a_out_valid, a_start, a_busy, a_in_ready); end
    a_fsm_ready = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (a_out_valid !== 1'b0 || a_start !== 2'b00) begin bad++; $display("FAIL rmid_late c=%0d got=%b/%b exp=0/00", c, a_out_valid, a_start); end
      step();
    end
  endtask

  task automatic test_random();
    tag_t exp_tag[$];
    aux_t exp_aux[$];
    int ndisp = 0;
    logic prev_stall = 0;
    tag_t prev_tag = '0;
    aux_t prev_aux = '0;
    logic [1:0] exp_start;
    do_reset();
    for (int cyc = 0; cyc < 430; cyc++) begin
      if (cyc < 400) begin
        a_in_valid  = ($urandom_range(0, 9) < 6);
        a_tag       = tag_t'($urandom);
        a_aux       = aux_t'($urandom);
        a_out_ready = ($urandom_range(0, 9) < 7);
        a_fsm_ready = 2'($urandom_range(0, 3));
      end else begin
        a_in_valid = 0; a_out_ready = 1; a_fsm_ready = 2'b11;
      end
      #1;
      exp_start = (a_in_valid && a_in_ready) ? (2'b01 << (ndisp % 2)) : 2'b00;
      total++; if (a_start !== exp_start) begin bad++; $display("FAIL rnd_start cyc=%0d got=%b exp=%b", cyc, a_start, exp_start); end
      if (a_in_valid && a_in_ready) begin
        exp_tag.push_back(a_tag); exp_aux.push_back(a_aux); ndisp++;
      end
      if (prev_stall) begin
        total++; if (a_out_valid !== 1'b1 || a_tag_o !== prev_tag || a_aux_o !== prev_aux)
          begin bad++; $display("FAIL rnd_hold cyc=%0d got=%b/%h/%h exp=1/%h/%h", cyc, a_out_valid, a_tag_o, a_aux_o, prev_tag, prev_aux); end
      end
      if (a_out_valid === 1'b1 && a_out_ready) begin
        total++;
        if (exp_tag.size() == 0) begin
          bad++; $display("FAIL rnd_spurious cyc=%0d got=%h exp=none", cyc, a_tag_o);
        end else begin
          if (a_tag_o !== exp_tag[0] || a_aux_o !== exp_aux[0]) begin
            bad++; $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h/%h", cyc, a_tag_o, a_aux_o, exp_tag[0], exp_aux[0]);
          end
          void'(exp_tag.pop_front()); void'(exp_aux.pop_front());
        end
      end
      prev_stall = (a_out_valid === 1'b1) && !a_out_ready;
      prev_tag = a_tag_o; prev_aux = a_aux_o;
      step();
    end
    #1;
    total++; if (exp_tag.size() != 0) begin bad++; $display("FAIL rnd_leftover got=%0d exp=0", exp_tag.size()); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rnd_busy got=%b exp=0", a_busy); end
    total++; if (ndisp < 50) begin bad++; $display("FAIL rnd_activity got=%0d exp=>=50", ndisp); end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_order();
    test_back_to_back();
    test_latency();
    test_stall();
    test_flush_priority();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
